// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg: shared types and constants for the remote_comm block.
//   rc_state_t  - command-sequencer state encoding (IDLE, HIGH, LOW)
//   ACK         - positive acknowledge byte returned by the Knight
//   RESP_TMO_W  - width of the optional response-timeout counter
package remote_comm_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} rc_state_t;

    localparam logic [7:0] ACK        = 8'hA5;
    localparam int         RESP_TMO_W = 24;

endpackage

// File: rtl/remote_comm_uart.sv
// remote_comm_uart: 8N1 UART transceiver with independent TX and RX paths.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   trmt, tx_data       - one-cycle load strobe and byte to transmit
//   tx_done             - sticky; set at end of stop bit, cleared by trmt
//   TX                  - serial out, idles high
//   RX                  - serial in (asynchronous, synchronized here)
//   rx_data, rx_rdy     - last received byte and its valid flag
//   clr_rx_rdy          - clears rx_rdy; a same-cycle new byte wins
// Parameter BAUD_DIV: clk cycles per bit.
module remote_comm_uart #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

    logic [9:0]  tx_shift;
    logic [3:0]  tx_bits;
    logic [15:0] tx_baud;
    logic        tx_busy;

    // Shift register is refilled with ones, so it naturally idles high.
    assign TX = tx_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_bits  <= '0;
            tx_baud  <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else if (trmt) begin
            tx_shift <= {1'b1, tx_data, 1'b0};
            tx_bits  <= '0;
            tx_baud  <= '0;
            tx_busy  <= 1'b1;
            tx_done  <= 1'b0;
        end else if (tx_busy) begin
            if (tx_baud == BAUD_LAST) begin
                tx_baud  <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud + 16'd1;
            end
        end
    end

    logic        rx_sync1, rx_sync2;
    logic        rx_busy;
    logic [3:0]  rx_bits;
    logic [15:0] rx_baud;
    logic [7:0]  rx_shift;
    logic        rx_set;

    // Sample point reached for the stop bit: byte complete.
    assign rx_set = rx_busy && (rx_baud == 16'd0) && (rx_bits == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_busy  <= 1'b0;
            rx_bits  <= '0;
            rx_baud  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else begin
            rx_sync1 <= RX;
            rx_sync2 <= rx_sync1;
            if (!rx_busy) begin
                if (!rx_sync2) begin
                    // First sample lands mid start bit, later ones mid data bit.
                    rx_busy <= 1'b1;
                    rx_baud <= BAUD_HALF;
                    rx_bits <= '0;
                end
            end else if (rx_baud == 16'd0) begin
                rx_baud <= BAUD_LAST;
                if (rx_bits == 4'd0) begin
                    if (rx_sync2) rx_busy <= 1'b0;   // glitch, not a start bit
                    else          rx_bits <= 4'd1;
                end else if (rx_bits != 4'd9) begin
                    rx_shift <= {rx_sync2, rx_shift[7:1]};
                    rx_bits  <= rx_bits + 4'd1;
                end else begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_shift;
                end
            end else begin
                rx_baud <= rx_baud - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rx_rdy <= 1'b0;
        else if (rx_set)     rx_rdy <= 1'b1;
        else if (clr_rx_rdy) rx_rdy <= 1'b0;
    end

endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command to the Knight as two UART bytes
// (high byte first) and presents the single-byte response.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cmd, snd_cmd        - command word and one-cycle send request
//   cmd_snt, busy       - command complete flag, transfer in progress
//   resp, resp_rdy      - last response byte and its valid flag
//   clr_resp_rdy        - clears resp_rdy
//   TX, RX              - serial link
//   resp_tmo            - sticky response timeout (RESP_TIMEOUT_EN only)
// Optional feature macro: RESP_TIMEOUT_EN (adds response-timeout counter).
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
`ifdef RESP_TIMEOUT_EN
    , parameter logic [RESP_TMO_W-1:0] RESP_TMO = 24'd5_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        busy,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy,
    output logic        TX,
`ifdef RESP_TIMEOUT_EN
    output logic        resp_tmo,
`endif
    input  logic        RX
);

    rc_state_t  state, state_nxt;
    logic [7:0] low_byte;
    logic [7:0] tx_data;
    logic       trmt, tx_done;
    logic       accept, set_snt;

    remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .TX         (TX),
        .RX         (RX),
        .rx_data    (resp),
        .rx_rdy     (resp_rdy),
        .clr_rx_rdy (clr_resp_rdy)
    );

    assign busy    = (state != IDLE);
    // High byte goes straight from cmd so trmt can fire in the accept cycle.
    assign tx_data = (state == IDLE) ? cmd[15:8] : low_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        trmt      = 1'b0;
        accept    = 1'b0;
        set_snt   = 1'b0;
        case (state)
            IDLE: if (snd_cmd) begin
                accept    = 1'b1;
                trmt      = 1'b1;
                state_nxt = HIGH;
            end
            HIGH: if (tx_done) begin
                trmt      = 1'b1;
                state_nxt = LOW;
            end
            LOW: if (tx_done) begin
                set_snt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_byte <= '0;
            cmd_snt  <= 1'b0;
        end else begin
            if (accept)  low_byte <= cmd[7:0];
            if (accept)  cmd_snt  <= 1'b0;
            else if (set_snt) cmd_snt <= 1'b1;
        end
    end

`ifdef RESP_TIMEOUT_EN
    logic [RESP_TMO_W-1:0] tmo_cnt;
    logic                  tmo_armed;
    logic                  resp_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt    <= '0;
            tmo_armed  <= 1'b0;
            resp_rdy_q <= 1'b0;
            resp_tmo   <= 1'b0;
        end else begin
            resp_rdy_q <= resp_rdy;
            if (accept) resp_tmo <= 1'b0;
            if (set_snt) begin
                tmo_cnt   <= '0;
                tmo_armed <= 1'b1;
            end else if (tmo_armed) begin
                if (resp_rdy && !resp_rdy_q) begin
                    tmo_armed <= 1'b0;
                end else if (!resp_rdy) begin
                    // Flag rises on the RESP_TMO-th counting edge after arming.
                    if (tmo_cnt == RESP_TMO - 1'b1) begin
                        resp_tmo  <= 1'b1;
                        tmo_armed <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: doc/remote_comm.md
# remote_comm

Command-side counterpart of the Knight's UART command receiver. Accepts a 16-bit command from the host/remote logic, serializes it over UART as two bytes (high byte first, then low byte), and signals completion. Also presents the single-byte response returned by the Knight (e.g. positive acknowledge 0xA5) with a ready/clear handshake. Sits between the remote-control or test logic and the serial link to the Knight.

## Interface
- RESP_TMO, 24'd5_000_000, response-timeout limit in clk cycles; used only when RESP_TIMEOUT_EN is defined.
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command word; sampled only in the cycle snd_cmd is accepted
- snd_cmd  in  1  single-cycle request to send cmd
- cmd_snt  out  1  set when the low byte finishes transmitting; cleared on the next accepted snd_cmd
- busy  out  1  high from acceptance of snd_cmd until the low byte completes
- resp  out  8  last received response byte
- resp_rdy  out  1  response byte valid; held until clr_resp_rdy or a new byte arrives
- clr_resp_rdy  in  1  clears resp_rdy
- TX  out  1  serial out; idles high
- RX  in  1  serial in
- resp_tmo  out  1  (RESP_TIMEOUT_EN only) sticky timeout flag

## Operation
- States: IDLE, HIGH, LOW. Shared enum comes from the package.
- IDLE: when snd_cmd=1, capture cmd[7:0] into low_byte, pulse trmt with tx_data=cmd[15:8] in the same cycle, clear cmd_snt, and go to HIGH. When snd_cmd=0, do nothing.
- HIGH: wait for tx_done. On tx_done, pulse trmt with tx_data=low_byte and go to LOW.
- LOW: wait for tx_done. On tx_done, set cmd_snt and return to IDLE.
- busy = (state != IDLE). snd_cmd is ignored while busy. It is not queued.
- tx_data mux: cmd[15:8] is used in IDLE only. low_byte is used otherwise. cmd may change freely after acceptance.
- UART tx_done is sticky: set at the end of the stop bit and cleared by trmt on the next edge. State HIGH and state LOW are each entered one cycle after their trmt, so a stale tx_done cannot be seen.
- Response path: the UART's rx_rdy drives resp_rdy directly and rx_data drives resp. clr_resp_rdy drives the UART's clr_rx_rdy. If a new byte arrives while resp_rdy=1, the old byte is overwritten.
- The receive and transmit directions are independent. A response arriving during transmission is still captured.
- Reset mid-operation: abort any byte in progress, return to IDLE, and release TX to 1. No partial command is resumed.

## Timing
- Reset values: cmd_snt=0, busy=0, resp_rdy=0, resp=8'h00, TX=1, resp_tmo=0, low_byte=0.
- trmt for the high byte is asserted in the same cycle snd_cmd is accepted. busy rises on the next edge.
- trmt for the low byte is asserted in the cycle tx_done is seen in HIGH. There is no idle gap beyond the UART's own start bit.
- cmd_snt rises one edge after tx_done is seen in LOW. busy falls on that same edge.
- Total latency is about 20 bit times plus 2 cycles. At 19200 baud and 50 MHz (2604 clk/bit) that is ≈52,082 cycles.
- snd_cmd arriving on the same edge that busy falls is not accepted. It is accepted on the next cycle.
- If clr_resp_rdy and a new byte arrive in the same cycle, set wins and resp_rdy stays 1.

## Configuration
- RESP_TIMEOUT_EN defined: adds a 24-bit counter that behaves as follows.
  - It is cleared and armed when cmd_snt is set.
  - It increments each cycle while armed and resp_rdy=0.
  - It disarms when resp_rdy rises.
  - At RESP_TMO it sets resp_tmo and disarms.
  - resp_tmo is cleared by the next accepted snd_cmd.
- RESP_TIMEOUT_EN undefined: no counter and no resp_tmo port. The behaviour is otherwise identical.

## Structure
- Shared package remote_comm_pkg holds:
  - typedef enum logic [1:0] {IDLE, HIGH, LOW} rc_state_t
  - localparam ACK = 8'hA5
  - localparam RESP_TMO_W = 24
- One sub-module: the existing UART (transceiver, used unmodified). All framing and sequencing lives in remote_comm.

## Test plan
- Reset with snd_cmd=0 → TX=1, cmd_snt=0, busy=0, resp_rdy=0 throughout 10k cycles.
- cmd=16'h5A3C, pulse snd_cmd → TX shows 0x5A then 0x3C, LSB first with start/stop bits; cmd_snt=1 at ≈52,082 cycles; busy low on the same edge.
- Second snd_cmd with cmd=16'hFFFF issued mid-transmission of 16'h1234 → ignored; TX carries only 0x12,0x34; cmd_snt set once.
- Drive RX with 0xA5 after cmd_snt → resp=8'hA5 and resp_rdy=1; clr_resp_rdy pulse → resp_rdy=0 next edge.
- Assert rst_n=0 during the low byte of 16'hBEEF → TX=1 immediately, state IDLE; a fresh snd_cmd with 16'h0001 sends 0x00,0x01 correctly.
- RESP_TIMEOUT_EN with RESP_TMO=1000 and no RX activity → resp_tmo=1 exactly 1000 cycles after cmd_snt; a response at cycle 999 leaves resp_tmo=0.
